// File: rtl/conv_pkg.sv
// conv_pkg: shared parameters, width helpers and FSM encoding for the convolution engine.
// Rev 1.0
`default_nettype none

package conv_pkg;

  localparam int INW   = 10;
  localparam int R     = 9;
  localparam int K     = 4;
  localparam int OUTW  = 24;

  localparam int XAW   = $clog2(R * R);
  localparam int WAW   = (K > 1) ? $clog2(K * K) : 1;
  localparam int PRODW = 2 * INW;
  localparam int CW    = $clog2(R + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // The result must hold K*K full-width products without overflow.
  function automatic bit outw_ok(input int outw, input int inw, input int k);
    return outw >= (2 * inw + $clog2(k * k));
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: r/c/i/j loop counters producing X/W read addresses and term flags.
// Rev 1.0
`default_nettype none

module conv_addr_gen
  import conv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [XAW-1:0] x_addr,
  output logic [WAW-1:0] w_addr,
  output logic           first_term,
  output logic           last_term,
  output logic           last_output
);

  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;

  logic [XAW-1:0] row, col;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  // j steps fastest, then i, then c, then r; everything wraps to zero after the last term.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    i_d = i_q;
    j_d = j_q;
    if (clear) begin
      r_d = '0;
      c_d = '0;
      i_d = '0;
      j_d = '0;
    end else if (advance) begin
      if (j_q == CW'(K - 1)) begin
        j_d = '0;
        if (i_q == CW'(K - 1)) begin
          i_d = '0;
          if (c_q == CW'(R - K)) begin
            c_d = '0;
            r_d = (r_q == CW'(R - K)) ? '0 : r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_comb begin
    row         = XAW'(r_q) + XAW'(i_q);
    col         = XAW'(c_q) + XAW'(j_q);
    x_addr      = row * XAW'(R) + col;
    w_addr      = WAW'(i_q) * WAW'(K) + WAW'(j_q);
    first_term  = (i_q == '0) && (j_q == '0);
    last_term   = (i_q == CW'(K - 1)) && (j_q == CW'(K - 1));
    last_output = (r_q == CW'(R - K)) && (c_q == CW'(R - K));
  end

endmodule

`default_nettype wire

// File: rtl/conv_engine.sv
// conv_engine: valid-mode 2D convolution, one multiply-accumulate term per cycle, AXI-Stream output.
// Rev 1.0
`default_nettype none

module conv_engine
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XAW-1:0]  x_addr,
  input  logic [INW-1:0]  x_data,
  output logic [WAW-1:0]  w_addr,
  input  logic [INW-1:0]  w_data,
  output logic [OUTW-1:0] OUT_AXIS_TDATA,
  output logic            OUT_AXIS_TVALID,
  output logic            OUT_AXIS_TLAST,
  input  logic            OUT_AXIS_TREADY
);

  if (!outw_ok(OUTW, INW, K)) begin : g_outw_check
    $error("conv_engine: OUTW too narrow for INW and K");
  end

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic pipe_advance, start_accept, issue, run_advance, last_issue, handshake;
  logic first_term, last_term, last_output;

  logic                    stalled_q, stalled_d;
  logic [INW-1:0]          x_hold_q, x_hold_d, w_hold_q, w_hold_d;
  logic signed [INW-1:0]   x_op, w_op;
  logic signed [PRODW-1:0] x_ext, w_ext;

  logic                    s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d, s1_lo_q, s1_lo_d;
  logic                    s2_valid_q, s2_valid_d, s2_first_q, s2_first_d;
  logic                    s2_last_q, s2_last_d, s2_lo_q, s2_lo_d;
  logic signed [PRODW-1:0] prod_q, prod_d;
  logic signed [OUTW-1:0]  acc_q, acc_d;
  logic                    acc_done_q, acc_done_d, acc_lo_q, acc_lo_d;
  logic [OUTW-1:0]         out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;

  // A held output beat freezes every stage, counters and FSM.
  assign pipe_advance = !(out_valid_q && !OUT_AXIS_TREADY);
  assign start_accept = (state_q == IDLE) && start && !done_q;
  assign issue        = (state_q == RUN);
  assign run_advance  = issue && pipe_advance;
  assign last_issue   = run_advance && last_term && last_output;
  assign handshake    = out_valid_q && OUT_AXIS_TREADY;

  conv_addr_gen u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_accept),
    .advance     (run_advance),
    .x_addr      (x_addr),
    .w_addr      (w_addr),
    .first_term  (first_term),
    .last_term   (last_term),
    .last_output (last_output)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_accept) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (handshake && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done is registered, so it lands in IDLE; start is refused while it is high.
  always_comb begin
    done_d = (state_q == DRAIN) && handshake && out_last_q;
    busy   = (state_q != IDLE) || done_q;
    done   = done_q;
  end

  // Memory data arriving in the first stalled cycle belongs to the frozen S1 term; keep it.
  assign x_op  = stalled_q ? x_hold_q : x_data;
  assign w_op  = stalled_q ? w_hold_q : w_data;
  assign x_ext = PRODW'(x_op);
  assign w_ext = PRODW'(w_op);

  always_comb begin
    stalled_d   = !pipe_advance;
    x_hold_d    = x_hold_q;
    w_hold_d    = w_hold_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_lo_d     = s1_lo_q;
    s2_valid_d  = s2_valid_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    s2_lo_d     = s2_lo_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    acc_done_d  = acc_done_q;
    acc_lo_d    = acc_lo_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (!pipe_advance && !stalled_q) begin
      x_hold_d = x_data;
      w_hold_d = w_data;
    end
    if (pipe_advance) begin
      s1_valid_d  = issue;
      s1_first_d  = first_term;
      s1_last_d   = last_term;
      s1_lo_d     = last_output;
      s2_valid_d  = s1_valid_q;
      s2_first_d  = s1_first_q;
      s2_last_d   = s1_last_q;
      s2_lo_d     = s1_lo_q;
      prod_d      = x_ext * w_ext;
      if (s2_valid_q) acc_d = s2_first_q ? OUTW'(prod_q) : acc_q + OUTW'(prod_q);
      acc_done_d  = s2_valid_q && s2_last_q;
      acc_lo_d    = s2_lo_q;
      out_valid_d = acc_done_q;
      out_last_d  = acc_done_q && acc_lo_q;
      if (acc_done_q) out_data_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      stalled_q   <= 1'b0;
      x_hold_q    <= '0;
      w_hold_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_lo_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_lo_q     <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      acc_done_q  <= 1'b0;
      acc_lo_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      done_q      <= done_d;
      stalled_q   <= stalled_d;
      x_hold_q    <= x_hold_d;
      w_hold_q    <= w_hold_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_lo_q     <= s1_lo_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_lo_q     <= s2_lo_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      acc_done_q  <= acc_done_d;
      acc_lo_q    <= acc_lo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign OUT_AXIS_TDATA  = out_data_q;
  assign OUT_AXIS_TVALID = out_valid_q;
  assign OUT_AXIS_TLAST  = out_last_q;

endmodule

`default_nettype wire
